// File: rtl/fetch_stage_if.sv
// fetch_stage_if -- handshake bundle between the fetch stage, instruction
// memory, the execute-stage redirect and the decode stage.
//   master : fetch stage side (drives imem request and decode outputs)
//   slave  : environment side (memory, execute and decode)
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  id_valid;
    logic                  id_ready;
    logic [DATA_WIDTH-1:0] id_instr;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_pc_plus4;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch with a one-deep memory pipeline and a
// 2-entry {instr, pc} skid FIFO towards decode.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_stage_if.master
//            imem_req/imem_addr/imem_rdata : always-ready memory, data one cycle later
//            redirect_valid/redirect_pc     : taken branch/jump from execute
//            id_valid/id_ready/id_instr/id_pc/id_pc_plus4 : decode handshake
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_stage_if.master  bus
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] inflight_pc_q;
    logic [DATA_WIDTH-1:0] instr_q [2];
    logic [DATA_WIDTH-1:0] epc_q   [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            cnt_q, cnt_d;

    logic                  wr_ptr;
    logic                  push, pop, req;
    logic [1:0]            occ_after;

    // Tail slot is head + count modulo 2; at count 2 it aliases the head,
    // which is only written together with a pop, so order is preserved.
    assign wr_ptr = rd_ptr_q ^ cnt_q[0];

    assign bus.id_valid    = (cnt_q != 2'd0) && !bus.redirect_valid;
    assign bus.id_instr    = instr_q[rd_ptr_q];
    assign bus.id_pc       = epc_q[rd_ptr_q];
    assign bus.id_pc_plus4 = epc_q[rd_ptr_q] + DATA_WIDTH'(4);

    assign pop  = bus.id_valid && bus.id_ready;
    assign push = inflight_q && !bus.redirect_valid;

    // Slots committed after this edge: surviving entries plus the response
    // landing now. Counting the in-flight response keeps the FIFO from overflowing.
    assign occ_after = cnt_q - {1'b0, pop} + {1'b0, inflight_q};

    // rst_n gates the request so nothing is issued while reset is held.
    assign req = rst_n && !bus.redirect_valid && (occ_after < 2'd2);

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = req;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (bus.redirect_valid) begin
            // Redirect wins over push and pop; the in-flight response is dropped.
            pc_d     = {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (req) pc_d = pc_q + DATA_WIDTH'(4);
            if (pop) rd_ptr_d = ~rd_ptr_q;
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Payload storage needs no reset: occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (req) inflight_pc_q <= pc_q;
        if (push) begin
            instr_q[wr_ptr] <= bus.imem_rdata;
            epc_q[wr_ptr]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if #(.DATA_WIDTH(32)) bus ();

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: next fetch address, one outstanding request, and the
    // ordered list of addresses whose data has arrived but not been consumed.
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_addr;
    logic [31:0] m_q[$];

    bit          pend;
    logic [31:0] pend_addr;
    bit          cur_rdy, cur_redir;
    logic [31:0] cur_rpc;

    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_plus4, o_instr;
    int          nreq;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0513;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_infl = 1'b0;
        m_pc   = 32'h0000_0000;
        pend   = 1'b0;
    endtask

    task automatic drive(input bit rdy, input bit redir, input logic [31:0] rpc);
        bus.imem_rdata     = pend ? instr_of(pend_addr) : $urandom;
        bus.id_ready       = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        cur_rdy   = rdy;
        cur_redir = redir;
        cur_rpc   = rpc;
    endtask

    task automatic check_update();
        bit ev, pop, er;
        o_req   = bus.imem_req;
        o_addr  = bus.imem_addr;
        o_valid = bus.id_valid;
        o_pc    = bus.id_pc;
        o_plus4 = bus.id_pc_plus4;
        o_instr = bus.id_instr;
        ev  = (m_q.size() > 0) && !cur_redir;
        pop = ev && cur_rdy;
        er  = !cur_redir && ((m_q.size() - int'(pop) + int'(m_infl)) < 2);
        chk("id_valid", 32'(o_valid), 32'(ev));
        chk("imem_req", 32'(o_req), 32'(er));
        if (er) chk("imem_addr", o_addr, m_pc);
        if (ev) begin
            chk("id_pc", o_pc, m_q[0]);
            chk("id_instr", o_instr, instr_of(m_q[0]));
            chk("id_pc_plus4", o_plus4, m_q[0] + 32'd4);
        end
        if (cur_redir) begin
            m_q.delete();
            m_infl = 1'b0;
            m_pc   = {cur_rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_infl_addr);
            m_infl      = er;
            m_infl_addr = m_pc;
            if (er) m_pc = m_pc + 32'd4;
        end
        pend      = o_req;
        pend_addr = o_addr;
    endtask

    task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        drive(rdy, redir, rpc);
        #1;
        check_update();
    endtask

    task automatic release_reset(input bit rdy);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(rdy, 1'b0, 32'h0);
        #1;
        check_update();
    endtask

    initial begin
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_rdata     = 32'h0;
        model_reset();

        // Held in reset: nothing requested, nothing valid.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.id_valid), 32'd0);

        // Streaming from reset with decode always ready.
        release_reset(1'b1);
        chk("c0_req", 32'(o_req), 32'd1);
        chk("c0_addr", o_addr, 32'h0);
        chk("c0_valid", 32'(o_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("c1_valid", 32'(o_valid), 32'd0);
        chk("c1_addr", o_addr, 32'h4);
        cycle(1'b1, 1'b0, 32'h0);
        chk("c2_valid", 32'(o_valid), 32'd1);
        chk("c2_pc", o_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("c3_pc", o_pc, 32'h4);
        cycle(1'b1, 1'b0, 32'h0);
        chk("c4_pc", o_pc, 32'h8);

        // Decode stalled for 5 cycles from reset: exactly two fetches.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        release_reset(1'b0);
        nreq = int'(o_req);
        repeat (4) begin
            cycle(1'b0, 1'b0, 32'h0);
            nreq += int'(o_req);
        end
        chk("stall_nreq", 32'(nreq), 32'd2);
        chk("stall_req", 32'(o_req), 32'd0);
        chk("stall_head", o_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("drain0", o_pc, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("drain1", o_pc, 32'h4);
        cycle(1'b1, 1'b0, 32'h0);
        chk("drain2", o_pc, 32'h8);

        // Fill the FIFO, then redirect to an unaligned target.
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0103);
        chk("redir_valid", 32'(o_valid), 32'd0);
        chk("redir_req", 32'(o_req), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_addr", o_addr, 32'h0000_0100);
        chk("redir_v1", 32'(o_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_v2", 32'(o_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_pc", o_pc, 32'h0000_0100);

        // Address wrap at the top of the space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_addr0", o_addr, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_pc0", o_pc, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_pc1", o_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", o_plus4, 32'h0000_0000);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_pc2", o_pc, 32'h0000_0000);

        // Half-cycle reset pulse while a request is outstanding.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("pulse_req", 32'(bus.imem_req), 32'd0);
        chk("pulse_valid", 32'(bus.id_valid), 32'd0);
        #4;
        rst_n = 1'b1;
        model_reset();
        #1;
        check_update();
        chk("pulse_addr", o_addr, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("pulse_v1", 32'(o_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("pulse_pc", o_pc, 32'h0);

        // Random stall/redirect stress against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            bit rdy, redir;
            rdy   = ($urandom_range(0, 99) < 70);
            redir = ($urandom_range(0, 99) < 6);
            rpc   = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
            cycle(rdy, redir, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
